// File: rtl/dma_axi_burst_mem_slave.sv
// AXI4 burst memory slave: independent write and read FSMs over one
// register array, with FIXED/INCR/WRAP bursts, WSTRB and SLVERR.
module dma_axi_burst_mem_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10,
  parameter int C_MEM_WORDS        = 64
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic [2:0]                      s_axi_awsize,
  input  logic [1:0]                      s_axi_awburst,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  input  logic [2:0]                      s_axi_arsize,
  input  logic [1:0]                      s_axi_arburst,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
);

  localparam int IDW = C_S_AXI_ID_WIDTH;
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int BPB = DW / 8;
  localparam int S   = $clog2(BPB);
  localparam int IW  = $clog2(C_MEM_WORDS);
  localparam logic [AW+8:0] LAST_W = (AW+9)'(C_MEM_WORDS - 1);
  localparam logic [1:0] B_FIXED = 2'b00;
  localparam logic [1:0] B_WRAP  = 2'b10;
  localparam logic [1:0] SLVERR  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Range check uses the last word the burst can touch
  function automatic logic bad_access(
    input logic [AW-1:0] a,
    input logic [7:0]    len,
    input logic [2:0]    size,
    input logic [1:0]    burst
  );
    logic [AW+8:0] w0;
    logic [AW+8:0] ln;
    logic [AW+8:0] last;
    logic          bad;
    w0 = {9'd0, a} >> S;
    ln = {{(AW+1){1'b0}}, len};
    case (burst)
      B_FIXED: last = w0;
      B_WRAP:  last = (w0 & ~ln) + ln;
      default: last = w0 + ln;
    endcase
    bad = (size != 3'(S)) || (burst == 2'b11) || (last > LAST_W);
    if (burst == B_WRAP)
      bad = bad || !(len == 8'd1 || len == 8'd3 ||
                     len == 8'd7 || len == 8'd15);
    return bad;
  endfunction

  function automatic logic [AW-1:0] next_addr(
    input logic [AW-1:0] a,
    input logic [7:0]    len,
    input logic [1:0]    burst
  );
    logic [AW-1:0] mask;
    logic [AW-1:0] nxt;
    mask = AW'(({24'd0, len} + 32'd1) * 32'(BPB) - 32'd1);
    case (burst)
      B_FIXED: nxt = a;
      B_WRAP:  nxt = (a & ~mask) | ((a + AW'(BPB)) & mask);
      default: nxt = a + AW'(BPB);
    endcase
    return nxt;
  endfunction

  logic [DW-1:0] mem [C_MEM_WORDS];

  w_state_t       w_state;
  logic [IDW-1:0] w_id;
  logic [AW-1:0]  w_addr;
  logic [7:0]     w_len;
  logic [7:0]     w_cnt;
  logic [1:0]     w_burst;
  logic           w_err;
  logic           w_mis;

  r_state_t       r_state;
  logic [AW-1:0]  r_addr;
  logic [7:0]     r_len;
  logic [7:0]     r_cnt;
  logic [1:0]     r_burst;
  logic           r_err;

  assign w_mis = s_axi_wlast != (w_cnt == w_len);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= '0;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_burst       <= '0;
      w_err         <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            w_id          <= s_axi_awid;
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_burst       <= s_axi_awburst;
            w_err         <= bad_access(s_axi_awaddr, s_axi_awlen,
                                        s_axi_awsize, s_axi_awburst);
            w_cnt         <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid && s_axi_wready) begin
            w_addr <= next_addr(w_addr, w_len, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            if (w_mis) w_err <= 1'b1;
            // Beat count, not WLAST, decides where the burst ends
            if (w_cnt == w_len) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= w_id;
              s_axi_bresp  <= (w_err || w_mis) ? SLVERR : 2'b00;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESETN && s_axi_wvalid && s_axi_wready && !w_err) begin
      for (int b = 0; b < BPB; b++)
        if (s_axi_wstrb[b])
          mem[w_addr[S +: IW]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= '0;
      s_axi_rlast   <= 1'b0;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_burst       <= '0;
      r_err         <= 1'b0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            r_addr        <= s_axi_araddr;
            r_len         <= s_axi_arlen;
            r_burst       <= s_axi_arburst;
            r_err         <= bad_access(s_axi_araddr, s_axi_arlen,
                                        s_axi_arsize, s_axi_arburst);
            r_cnt         <= '0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rid     <= s_axi_arid;
            s_axi_rresp   <= bad_access(s_axi_araddr, s_axi_arlen,
                                        s_axi_arsize, s_axi_arburst)
                             ? SLVERR : 2'b00;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rvalid && s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_rresp   <= 2'b00;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_addr      <= next_addr(r_addr, r_len, r_burst);
              r_cnt       <= r_cnt + 8'd1;
              s_axi_rlast <= (r_cnt + 8'd1 == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Read port is combinational off the registered address
  assign s_axi_rdata = (s_axi_rvalid && !r_err) ?
                       mem[r_addr[S +: IW]] : '0;

endmodule

// File: tb/tb_dma_axi_burst_mem_slave.sv
// Directed bench for dma_axi_burst_mem_slave: vector table of
// bursts plus sequences for concurrency, stalls and mid-burst reset.
module tb_dma_axi_burst_mem_slave;

  logic        clk;
  logic        aresetn;
  logic [0:0]  awid;
  logic [9:0]  awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [0:0]  arid;
  logic [9:0]  araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [0:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_chk = 0;
  int n_fail = 0;

  dma_axi_burst_mem_slave dut (
    .ACLK(clk), .ARESETN(aresetn),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          wr;
    logic        id;
    logic [9:0]  addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] d [8];
    logic [1:0]  resp;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic id, input logic [9:0] addr,
                          input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] strb,
                          input logic [31:0] d [8], input logic [1:0] er,
                          input int stall_b, input int bad_last);
    int n;
    awid = id; awaddr = addr; awlen = len;
    awburst = burst; awsize = size; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin tick(); n++; end
    chk("aw_handshake", awready, 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = d[i % 8]; wstrb = strb;
      wlast = (i == int'(len)) ^ (i == bad_last);
      wvalid = 1'b1;
      n = 0;
      while (wready !== 1'b1 && n < 50) begin tick(); n++; end
      chk("w_handshake", wready, 1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = (stall_b == 0);
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin tick(); n++; end
    chk("bvalid", bvalid, 1);
    for (int i = 0; i < stall_b; i++) begin
      tick();
      chk("bvalid_hold", bvalid, 1);
    end
    bready = 1'b1;
    chk("bresp", bresp, er);
    chk("bid", bid, id);
    tick();
    bready = 1'b0;
    chk("bvalid_clear", bvalid, 0);
  endtask

  task automatic do_read(input logic id, input logic [9:0] addr,
                         input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [31:0] d [8],
                         input logic [1:0] er, input bit toggle);
    int n;
    int beat;
    arid = id; araddr = addr; arlen = len;
    arburst = burst; arsize = size; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin tick(); n++; end
    chk("ar_handshake", arready, 1);
    tick();
    arvalid = 1'b0;
    beat = 0; n = 0;
    while (beat <= int'(len) && n < 100) begin
      rready = toggle ? ((n % 2) == 0) : 1'b1;
      chk("rvalid", rvalid, 1);
      chk($sformatf("rdata[%0d]", beat), rdata, d[beat % 8]);
      chk($sformatf("rresp[%0d]", beat), rresp, er);
      chk($sformatf("rlast[%0d]", beat), rlast, beat == int'(len));
      chk("rid", rid, id);
      if (rvalid === 1'b1 && rready) beat++;
      tick();
      n++;
    end
    rready = 1'b0;
    chk("r_beats", beat, int'(len) + 1);
    chk("rvalid_clear", rvalid, 0);
  endtask

  logic [31:0] z8 [8];
  logic [31:0] rd8 [8];

  initial begin
    z8 = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[0]  = '{1, 0, 10'h000, 7, 2'b01, 3'd2, 4'hF,
                 '{1, 2, 3, 4, 5, 6, 7, 8}, 2'b00};
    vecs[1]  = '{0, 1, 10'h000, 7, 2'b01, 3'd2, 4'hF,
                 '{1, 2, 3, 4, 5, 6, 7, 8}, 2'b00};
    vecs[2]  = '{1, 1, 10'h008, 3, 2'b10, 3'd2, 4'hF,
                 '{32'hA, 32'hB, 32'hC, 32'hD, 0, 0, 0, 0}, 2'b00};
    vecs[3]  = '{0, 0, 10'h000, 3, 2'b01, 3'd2, 4'hF,
                 '{32'hC, 32'hD, 32'hA, 32'hB, 0, 0, 0, 0}, 2'b00};
    vecs[4]  = '{1, 0, 10'h010, 0, 2'b01, 3'd2, 4'hF,
                 '{32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0}, 2'b00};
    vecs[5]  = '{1, 0, 10'h010, 0, 2'b01, 3'd2, 4'h5,
                 '{32'h1234_5678, 0, 0, 0, 0, 0, 0, 0}, 2'b00};
    vecs[6]  = '{0, 1, 10'h010, 0, 2'b01, 3'd2, 4'hF,
                 '{32'hFF34_FF78, 0, 0, 0, 0, 0, 0, 0}, 2'b00};
    vecs[7]  = '{1, 1, 10'h0F8, 1, 2'b01, 3'd2, 4'hF,
                 '{32'h55, 32'h66, 0, 0, 0, 0, 0, 0}, 2'b00};
    vecs[8]  = '{1, 0, 10'h0F8, 3, 2'b01, 3'd2, 4'hF,
                 '{32'h99, 32'h9A, 32'h9B, 32'h9C, 0, 0, 0, 0}, 2'b10};
    vecs[9]  = '{0, 0, 10'h0F8, 1, 2'b01, 3'd2, 4'hF,
                 '{32'h55, 32'h66, 0, 0, 0, 0, 0, 0}, 2'b00};
    vecs[10] = '{0, 1, 10'h0F8, 3, 2'b01, 3'd2, 4'hF, z8, 2'b10};
    vecs[11] = '{1, 0, 10'h020, 0, 2'b01, 3'd1, 4'hF,
                 '{32'hDEAD, 0, 0, 0, 0, 0, 0, 0}, 2'b10};
    vecs[12] = '{0, 0, 10'h000, 2, 2'b10, 3'd2, 4'hF, z8, 2'b10};
    vecs[13] = '{0, 1, 10'h004, 2, 2'b00, 3'd2, 4'hF,
                 '{32'hD, 32'hD, 32'hD, 0, 0, 0, 0, 0}, 2'b00};
    vecs[14] = '{1, 1, 10'h000, 0, 2'b11, 3'd2, 4'hF,
                 '{32'hBEEF, 0, 0, 0, 0, 0, 0, 0}, 2'b10};
    vecs[15] = '{0, 0, 10'h000, 3, 2'b01, 3'd2, 4'hF,
                 '{32'hC, 32'hD, 32'hA, 32'hB, 0, 0, 0, 0}, 2'b00};
    vecs[16] = '{0, 1, 10'h00C, 3, 2'b10, 3'd2, 4'hF,
                 '{32'hB, 32'hC, 32'hD, 32'hA, 0, 0, 0, 0}, 2'b00};

    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
    wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    arvalid = 1'b0; rready = 1'b0;
    repeat (3) tick();
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", {bid, bresp}, 0);
    chk("rst_rout", {rid, rresp, rlast, rdata}, 0);
    aresetn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr)
        do_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].burst,
                 vecs[i].size, vecs[i].strb, vecs[i].d, vecs[i].resp,
                 0, -1);
      else
        do_read(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].burst,
                vecs[i].size, vecs[i].d, vecs[i].resp, 1'b0);
    end

    // WLAST early on beat 0 of a 2-beat burst
    rd8 = '{32'h77, 32'h88, 0, 0, 0, 0, 0, 0};
    do_write(1'b0, 10'h060, 8'd1, 2'b01, 3'd2, 4'hF, rd8, 2'b10, 0, 0);

    // AW and AR together; R stalled every other cycle, B held off
    rd8 = '{32'h1111, 32'h2222, 0, 0, 0, 0, 0, 0};
    fork
      do_write(1'b1, 10'h040, 8'd1, 2'b01, 3'd2, 4'hF, rd8, 2'b00,
               5, -1);
      do_read(1'b0, 10'h000, 8'd3, 2'b01, 3'd2,
              '{32'hC, 32'hD, 32'hA, 32'hB, 0, 0, 0, 0}, 2'b00, 1'b1);
    join
    do_read(1'b1, 10'h040, 8'd1, 2'b01, 3'd2, rd8, 2'b00, 1'b0);

    // Reset during beat 3 of an 8-beat write
    awid = 1'b0; awaddr = 10'h080; awlen = 8'd7;
    awburst = 2'b01; awsize = 3'd2; awvalid = 1'b1;
    for (int n = 0; n < 50 && awready !== 1'b1; n++) tick();
    chk("rst_seq_aw", awready, 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wdata = 32'h6000_0000 + i; wstrb = 4'hF; wlast = 1'b0;
      wvalid = 1'b1;
      for (int n = 0; n < 50 && wready !== 1'b1; n++) tick();
      chk("rst_seq_w", wready, 1);
      tick();
    end
    wdata = 32'h6000_0003;
    aresetn = 1'b0;
    tick();
    chk("midrst_wready", wready, 0);
    chk("midrst_bvalid", bvalid, 0);
    aresetn = 1'b1;
    wvalid = 1'b0;
    bready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_b", bvalid, 0);
    end
    bready = 1'b0;
    rd8 = '{32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 0, 0, 0, 0, 0};
    do_read(1'b0, 10'h080, 8'd2, 2'b01, 3'd2, rd8, 2'b00, 1'b0);
    rd8 = '{32'h71, 32'h72, 32'h73, 32'h74, 32'h75, 32'h76,
            32'h77, 32'h78};
    do_write(1'b1, 10'h080, 8'd7, 2'b01, 3'd2, 4'hF, rd8, 2'b00, 0, -1);
    do_read(1'b1, 10'h080, 8'd7, 2'b01, 3'd2, rd8, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
